piradspi_cmd_queue: RTL

- Next-generation SPI control/status block. It holds NUM_PROFILES timing profiles and a CMD_DEPTH-entry command queue.
- Each register write to ENQUEUE snapshots the selected profile, the device and the command ID into one queue entry. The engine drains entries through a valid/ready command port.
- Interrupt coalescing is added: the interrupt is raised on a completion-count threshold or on a timeout.
- Sits between the AXI4-Lite register server (decoded register port) and the SPI engine.

---
 rtl/piradspi_pkg.sv | 82 ++++++++
 rtl/piradip_sync_fifo.sv | 59 +++++
 rtl/piradspi_cmd_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/piradspi_pkg.sv
// piradspi_pkg: shared types and constants for the SPI command queue.
//   wait_t / xfer_len_t : 8-bit timing fields of a profile
//   profile_t           : one timing profile (cpol, cpha, four waits, transfer length)
//   cmd_t               : one queued command (profile snapshot, command ID, device select)
//   REG_* / REGISTER_*  : register numbers; profile p field k lives at PROFBASE + PROFSIZE*p + k
//   prof_field()        : read view of one profile field
package piradspi_pkg;

    localparam int unsigned CMD_ID_WIDTH  = 16;
    localparam int unsigned CMD_DEV_WIDTH = 8;

    typedef logic [7:0] wait_t;
    typedef logic [7:0] xfer_len_t;

    typedef struct packed {
        logic      cpol;
        logic      cpha;
        wait_t     sclk_div;
        wait_t     start_wait;
        wait_t     csn_to_sclk;
        wait_t     sclk_to_csn;
        xfer_len_t xfer_len;
    } profile_t;

    typedef struct packed {
        profile_t                 prof;
        logic [CMD_ID_WIDTH-1:0]  id;
        logic [CMD_DEV_WIDTH-1:0] device;
    } cmd_t;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_STATUS   = 1;
    localparam int unsigned REG_CMD_ID   = 2;
    localparam int unsigned REG_ENQUEUE  = 3;
    localparam int unsigned REG_CMPLCNT  = 4;
    localparam int unsigned REG_COALESCE = 5;
    localparam int unsigned REG_INTRACK  = 6;

    localparam int unsigned REGISTER_PROFBASE = 16;
    localparam int unsigned REGISTER_PROFSIZE = 8;

    localparam logic [2:0] PROF_POLPHA    = 3'd0;
    localparam logic [2:0] PROF_SCLKDIV   = 3'd1;
    localparam logic [2:0] PROF_STARTWAIT = 3'd2;
    localparam logic [2:0] PROF_CSNTOSCLK = 3'd3;
    localparam logic [2:0] PROF_SCLKTOCSN = 3'd4;
    localparam logic [2:0] PROF_XFERLEN   = 3'd5;

    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_AUTOINC_BIT = 1;
    localparam int unsigned CTRL_INTR_EN_BIT = 2;
    localparam int unsigned CTRL_FLUSH_BIT   = 3;

    localparam int unsigned STATUS_EMPTY_BIT    = 16;
    localparam int unsigned STATUS_FULL_BIT     = 17;
    localparam int unsigned STATUS_BUSY_BIT     = 18;
    localparam int unsigned STATUS_OVERFLOW_BIT = 31;

    localparam profile_t PROFILE_RESET = '{
        cpol:        1'b0,
        cpha:        1'b0,
        sclk_div:    8'hFF,
        start_wait:  8'hFF,
        csn_to_sclk: 8'hFF,
        sclk_to_csn: 8'hFF,
        xfer_len:    8'd8
    };

    // POLPHA packs cpol in bit 0 and cpha in bit 1; fields 6 and 7 are holes.
    function automatic wait_t prof_field(profile_t p, logic [2:0] k);
        case (k)
            PROF_POLPHA:    return {6'b0, p.cpha, p.cpol};
            PROF_SCLKDIV:   return p.sclk_div;
            PROF_STARTWAIT: return p.start_wait;
            PROF_CSNTOSCLK: return p.csn_to_sclk;
            PROF_SCLKTOCSN: return p.sclk_to_csn;
            PROF_XFERLEN:   return p.xfer_len;
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/piradip_sync_fifo.sv
// piradip_sync_fifo: show-ahead synchronous FIFO.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i, data_i : write request and data (taken when not full, or when popping)
//   pop_i          : remove head (ignored when empty)
//   flush_i        : empty the FIFO in one cycle
//   data_o         : current head, valid while !empty_o
//   count_o, full_o, empty_o : occupancy
module piradip_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so a push into a full FIFO is legal then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/piradspi_cmd_queue.sv
// piradspi_cmd_queue: SPI control/status registers, timing profiles, command queue and
// coalesced completion interrupt.
//   aclk, areset               : clock, asynchronous active-high reset
//   wren/wreg_no/wdata/wstrb   : decoded register write port (byte enables)
//   rden/rreg_no/rreg_data     : decoded register read port (combinational data)
//   cmd_valid/cmd_ready/cmd    : command head towards the SPI engine
//   command_completed          : one-cycle completion pulse from the engine
//   engine_busy                : engine status, reflected in STATUS
//   engine_enable, intr_out    : CTRL enable bit, level interrupt
// ID_WIDTH and DEV_WIDTH must match the widths fixed in cmd_t.
module piradspi_cmd_queue
    import piradspi_pkg::*;
#(
    parameter int unsigned NUM_PROFILES       = 8,
    parameter int unsigned CMD_DEPTH          = 16,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned REGISTER_ADDR_BITS = 10,
    parameter int unsigned ID_WIDTH           = CMD_ID_WIDTH,
    parameter int unsigned DEV_WIDTH          = CMD_DEV_WIDTH
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          wren,
    input  logic [REGISTER_ADDR_BITS-1:0] wreg_no,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          rden,
    input  logic [REGISTER_ADDR_BITS-1:0] rreg_no,
    output logic [DATA_WIDTH-1:0]         rreg_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output cmd_t                          cmd,
    input  logic                          command_completed,
    input  logic                          engine_busy,
    output logic                          engine_enable,
    output logic                          intr_out
);
    localparam int unsigned PROF_BITS = $clog2(NUM_PROFILES);
    localparam int unsigned CNT_BITS  = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned PROF_END  = REGISTER_PROFBASE + REGISTER_PROFSIZE * NUM_PROFILES;

    logic enable_q, enable_d, autoinc_q, autoinc_d, intr_en_q, intr_en_d;
    logic overflow_q, overflow_d, intr_q, intr_d, hold_q, hold_d;
    logic [ID_WIDTH-1:0]         cmd_id_q, cmd_id_d;
    logic [7:0]                  threshold_q, threshold_d, pending_q, pending_d, thr_eff;
    logic [23:0]                 timeout_q, timeout_d, timer_q, timer_d;
    logic [31:0]                 cmplcnt_q, cmplcnt_d;
    profile_t [NUM_PROFILES-1:0] profiles_q, profiles_d;

    logic [DATA_WIDTH-1:0] wmask, wdata_m, rdata;
    int unsigned           waddr, raddr;
    logic [PROF_BITS-1:0]  wprof, rprof;
    logic [2:0]            wfield, rfield;
    logic wr_ctrl, wr_status, wr_cmdid, wr_enq, wr_cmplcnt, wr_coal, wr_intrack, wr_prof;
    logic pop, enq_ok, flush, unused_wdata;
    cmd_t                  entry;
    logic [CNT_BITS-1:0]   q_count;
    logic                  q_full, q_empty;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) wmask[8*b +: 8] = {8{wstrb[b]}};
    end

    assign wdata_m      = wdata & wmask;
    assign unused_wdata = ^wdata_m;
    assign waddr        = 32'(wreg_no);
    assign raddr        = 32'(rreg_no);

    assign wr_ctrl    = wren && waddr == REG_CTRL;
    assign wr_status  = wren && waddr == REG_STATUS;
    assign wr_cmdid   = wren && waddr == REG_CMD_ID;
    assign wr_enq     = wren && waddr == REG_ENQUEUE;
    assign wr_cmplcnt = wren && waddr == REG_CMPLCNT;
    assign wr_coal    = wren && waddr == REG_COALESCE;
    assign wr_intrack = wren && waddr == REG_INTRACK;
    assign wr_prof    = wren && waddr >= REGISTER_PROFBASE && waddr < PROF_END;
    assign wprof      = PROF_BITS'((waddr - REGISTER_PROFBASE) / REGISTER_PROFSIZE);
    assign wfield     = 3'((waddr - REGISTER_PROFBASE) % REGISTER_PROFSIZE);
    assign rprof      = PROF_BITS'((raddr - REGISTER_PROFBASE) / REGISTER_PROFSIZE);
    assign rfield     = 3'((raddr - REGISTER_PROFBASE) % REGISTER_PROFSIZE);

    // hold_q keeps an offered head valid until taken, even if enable drops meanwhile.
    assign cmd_valid = hold_q | (~q_empty & enable_q);
    assign pop       = cmd_valid & cmd_ready;
    assign enq_ok    = wr_enq & (~q_full | pop);
    assign flush     = wr_ctrl & wdata_m[CTRL_FLUSH_BIT] & ~enable_q & ~cmd_valid;

    // Profile index uses only the low bits, so out-of-range indices wrap.
    always_comb begin
        entry = '{prof:   profiles_q[wdata_m[PROF_BITS-1:0]],
                  id:     cmd_id_q,
                  device: wdata_m[16 +: DEV_WIDTH]};
    end

    piradip_sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (enq_ok),
        .data_i  (entry),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (cmd),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign thr_eff = (threshold_q == 8'd0) ? 8'd1 : threshold_q;

    always_comb begin
        enable_d    = enable_q;
        autoinc_d   = autoinc_q;
        intr_en_d   = intr_en_q;
        overflow_d  = overflow_q;
        cmd_id_d    = cmd_id_q;
        threshold_d = threshold_q;
        timeout_d   = timeout_q;
        profiles_d  = profiles_q;
        hold_d      = cmd_valid & ~cmd_ready;

        if (wr_ctrl && wstrb[0]) begin
            enable_d  = wdata_m[CTRL_ENABLE_BIT];
            autoinc_d = wdata_m[CTRL_AUTOINC_BIT];
            intr_en_d = wdata_m[CTRL_INTR_EN_BIT];
        end
        if (wr_status && wdata_m[STATUS_OVERFLOW_BIT]) overflow_d = 1'b0;
        if (wr_enq && !enq_ok)                         overflow_d = 1'b1;

        if (wr_cmdid) begin
            cmd_id_d = (cmd_id_q & ~wmask[ID_WIDTH-1:0]) | wdata_m[ID_WIDTH-1:0];
        end else if (enq_ok && autoinc_q) begin
            cmd_id_d = cmd_id_q + 1'b1;
        end

        if (wr_coal) begin
            threshold_d = (threshold_q & ~wmask[7:0]) | wdata_m[7:0];
            timeout_d   = (timeout_q & ~wmask[31:8]) | wdata_m[31:8];
        end

        if (wr_prof && wstrb[0]) begin
            case (wfield)
                PROF_POLPHA: begin
                    profiles_d[wprof].cpol = wdata_m[0];
                    profiles_d[wprof].cpha = wdata_m[1];
                end
                PROF_SCLKDIV:   profiles_d[wprof].sclk_div    = wdata_m[7:0];
                PROF_STARTWAIT: profiles_d[wprof].start_wait  = wdata_m[7:0];
                PROF_CSNTOSCLK: profiles_d[wprof].csn_to_sclk = wdata_m[7:0];
                PROF_SCLKTOCSN: profiles_d[wprof].sclk_to_csn = wdata_m[7:0];
                PROF_XFERLEN:   profiles_d[wprof].xfer_len    = wdata_m[7:0];
                default: ;
            endcase
        end

        cmplcnt_d = (wr_cmplcnt ? 32'd0 : cmplcnt_q) + 32'(command_completed);

        // Coalescing: an ack restarts from the completion arriving with it, if any.
        if (wr_intrack) begin
            pending_d = {7'd0, command_completed};
            timer_d   = '0;
            intr_d    = 1'b0;
        end else begin
            pending_d = (command_completed && pending_q != 8'hFF) ? pending_q + 8'd1 : pending_q;
            if (pending_q == 8'd0)      timer_d = '0;
            else if (&timer_q)          timer_d = timer_q;
            else                        timer_d = timer_q + 24'd1;
            intr_d = intr_q | (pending_d >= thr_eff)
                            | (timeout_q != 24'd0 && timer_d == timeout_q);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            enable_q    <= 1'b0;
            autoinc_q   <= 1'b0;
            intr_en_q   <= 1'b0;
            overflow_q  <= 1'b0;
            intr_q      <= 1'b0;
            hold_q      <= 1'b0;
            cmd_id_q    <= '0;
            threshold_q <= 8'd1;
            timeout_q   <= '0;
            pending_q   <= '0;
            timer_q     <= '0;
            cmplcnt_q   <= '0;
            profiles_q  <= {NUM_PROFILES{PROFILE_RESET}};
        end else begin
            enable_q    <= enable_d;
            autoinc_q   <= autoinc_d;
            intr_en_q   <= intr_en_d;
            overflow_q  <= overflow_d;
            intr_q      <= intr_d;
            hold_q      <= hold_d;
            cmd_id_q    <= cmd_id_d;
            threshold_q <= threshold_d;
            timeout_q   <= timeout_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            cmplcnt_q   <= cmplcnt_d;
            profiles_q  <= profiles_d;
        end
    end

    // Reads see register state only, so a same-cycle write is not yet visible.
    always_comb begin
        rdata = '0;
        case (raddr)
            REG_CTRL:     rdata[2:0] = {intr_en_q, autoinc_q, enable_q};
            REG_STATUS: begin
                rdata[15:0]                = 16'(q_count);
                rdata[STATUS_EMPTY_BIT]    = q_empty;
                rdata[STATUS_FULL_BIT]     = q_full;
                rdata[STATUS_BUSY_BIT]     = engine_busy;
                rdata[STATUS_OVERFLOW_BIT] = overflow_q;
            end
            REG_CMD_ID:   rdata[ID_WIDTH-1:0] = cmd_id_q;
            REG_CMPLCNT:  rdata[31:0] = cmplcnt_q;
            REG_COALESCE: rdata[31:0] = {timeout_q, threshold_q};
            default: begin
                if (raddr >= REGISTER_PROFBASE && raddr < PROF_END) begin
                    rdata[7:0] = prof_field(profiles_q[rprof], rfield);
                end
            end
        endcase
    end

    assign rreg_data     = rden ? rdata : '0;
    assign engine_enable = enable_q;
    assign intr_out      = intr_q & intr_en_q;

endmodule
